// File: rtl/ntt_ctrl_if.sv
// ============================================================
// ntt_ctrl_if : operation / writeback bus between sequencer and butterfly datapath
// Revision    : 1.0
// ============================================================
`default_nettype none

interface ntt_ctrl_if;
   logic       op_valid;
   logic       op_ready;
   logic       op_scale;
   logic       op_inv;
   logic [7:0] addr_a;
   logic [7:0] addr_b;
   logic [6:0] zeta_addr;
   logic       wb_done;

   modport master (
      output op_valid,
      output op_scale,
      output op_inv,
      output addr_a,
      output addr_b,
      output zeta_addr,
      input  op_ready,
      input  wb_done
   );

   modport slave (
      input  op_valid,
      input  op_scale,
      input  op_inv,
      input  addr_a,
      input  addr_b,
      input  zeta_addr,
      output op_ready,
      output wb_done
   );
endinterface

`default_nettype wire

// File: rtl/ntt_ctrl.sv
// ============================================================
// ntt_ctrl : Kyber NTT/INTT butterfly address, twiddle and layer-barrier sequencer
// Revision : 1.0
// ============================================================
`default_nettype none

module ntt_ctrl #(
   parameter int PIPE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        inverse,
   output logic        busy,
   output logic        done,
   output logic [2:0]  layer,
   ntt_ctrl_if.master  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_SCALE  = 3'd3;
   localparam logic [2:0] S_SDRAIN = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [7:0] c_pipe_max = 8'(PIPE_MAX);

   logic [2:0] r_state;
   logic       r_inv;
   logic [2:0] r_layer;
   logic [6:0] r_b;
   logic [7:0] r_s;
   logic [7:0] r_outst;
   logic [7:0] r_addr_a;
   logic [7:0] r_addr_b;
   logic [6:0] r_zeta;
   logic       r_scale;

   logic [2:0] w_nxt_state;
   logic       w_nxt_inv;
   logic [2:0] w_nxt_layer;
   logic [6:0] w_nxt_b;
   logic [7:0] w_nxt_s;
   logic [7:0] w_nxt_outst;
   logic       w_xfer;
   logic       w_valid;

   logic [2:0] w_len_log;
   logic [3:0] w_shamt;
   logic [7:0] w_len;
   logic [6:0] w_grp;
   logic [6:0] w_off;
   logic [7:0] w_base;
   logic [7:0] w_addr_a;
   logic [7:0] w_addr_b;
   logic [6:0] w_zeta;

   assign w_xfer = w_valid & bus.op_ready;

   // State register plus all sequencing counters and the registered operation outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_inv    <= 1'b0;
         r_layer  <= 3'd0;
         r_b      <= 7'd0;
         r_s      <= 8'd0;
         r_outst  <= 8'd0;
         r_addr_a <= 8'd0;
         r_addr_b <= 8'd0;
         r_zeta   <= 7'd0;
         r_scale  <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_inv    <= w_nxt_inv;
         r_layer  <= w_nxt_layer;
         r_b      <= w_nxt_b;
         r_s      <= w_nxt_s;
         r_outst  <= w_nxt_outst;
         case (w_nxt_state)
            S_ISSUE: begin
               r_addr_a <= w_addr_a;
               r_addr_b <= w_addr_b;
               r_zeta   <= w_zeta;
               r_scale  <= 1'b0;
            end
            S_SCALE: begin
               r_addr_a <= w_nxt_s;
               r_addr_b <= 8'd0;
               r_zeta   <= 7'd0;
               r_scale  <= 1'b1;
            end
            default: begin
               r_addr_a <= 8'd0;
               r_addr_b <= 8'd0;
               r_zeta   <= 7'd0;
               r_scale  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_inv   = r_inv;
      w_nxt_layer = r_layer;
      w_nxt_b     = r_b;
      w_nxt_s     = r_s;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nxt_state = S_ISSUE;
               w_nxt_inv   = inverse;
               w_nxt_layer = 3'd0;
               w_nxt_b     = 7'd0;
            end
         end
         S_ISSUE: begin
            if (w_xfer) begin
               w_nxt_b = r_b + 7'd1;
               if (r_b == 7'd127) begin
                  w_nxt_state = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Barrier: the next layer reads coefficients this layer is still writing.
            if (r_outst == 8'd0) begin
               if (r_layer != 3'd6) begin
                  w_nxt_state = S_ISSUE;
                  w_nxt_layer = r_layer + 3'd1;
                  w_nxt_b     = 7'd0;
               end else if (r_inv) begin
                  w_nxt_state = S_SCALE;
                  w_nxt_layer = 3'd7;
                  w_nxt_s     = 8'd0;
               end else begin
                  w_nxt_state = S_DONE;
               end
            end
         end
         S_SCALE: begin
            if (w_xfer) begin
               w_nxt_s = r_s + 8'd1;
               if (r_s == 8'd255) begin
                  w_nxt_state = S_SDRAIN;
               end
            end
         end
         S_SDRAIN: begin
            if (r_outst == 8'd0) begin
               w_nxt_state = S_DONE;
            end
         end
         S_DONE: begin
            w_nxt_state = S_IDLE;
            w_nxt_layer = 3'd0;
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      w_valid = 1'b0;
      case (r_state)
         S_ISSUE, S_SCALE: begin
            busy    = 1'b1;
            w_valid = (r_outst != c_pipe_max);
         end
         S_DRAIN, S_SDRAIN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Outstanding count saturates at zero so writebacks from an aborted transform are harmless.
   always_comb begin
      w_nxt_outst = r_outst;
      if (w_xfer && !bus.wb_done) begin
         w_nxt_outst = r_outst + 8'd1;
      end else if (!w_xfer && bus.wb_done && (r_outst != 8'd0)) begin
         w_nxt_outst = r_outst - 8'd1;
      end
   end

   // Address math is evaluated on the next-cycle butterfly so the outputs can be registered.
   always_comb begin
      w_len_log = w_nxt_inv ? (w_nxt_layer + 3'd1) : (3'd7 - w_nxt_layer);
      w_shamt   = {1'b0, w_len_log} + 4'd1;
      w_len     = 8'd1 << w_len_log;
      w_grp     = w_nxt_b >> w_len_log;
      w_off     = w_nxt_b & (w_len[6:0] - 7'd1);
      w_base    = {1'b0, w_grp} << w_shamt;
      w_addr_a  = w_base + {1'b0, w_off};
      w_addr_b  = w_addr_a + w_len;
      if (w_nxt_inv) begin
         w_zeta = 7'((9'd256 >> w_len_log) - 9'd1 - {2'b00, w_grp});
      end else begin
         w_zeta = 7'((8'd128 >> w_len_log) + {1'b0, w_grp});
      end
   end

   assign bus.op_valid  = w_valid;
   assign bus.op_scale  = r_scale;
   assign bus.op_inv    = r_inv;
   assign bus.addr_a    = r_addr_a;
   assign bus.addr_b    = r_addr_b;
   assign bus.zeta_addr = r_zeta;
   assign layer         = r_layer;

endmodule

`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
// ============================================================
// tb_ntt_ctrl : directed bench for the NTT sequencer against a reference loop nest
// Revision    : 1.0
// ============================================================
`default_nettype none

module tb_ntt_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       inverse;
   logic       busy;
   logic       done;
   logic [2:0] layer;

   ntt_ctrl_if bus_if ();

   ntt_ctrl #(.PIPE_MAX(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .inverse (inverse),
      .busy    (busy),
      .done    (done),
      .layer   (layer),
      .bus     (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int  cyc       = 0;
   int  wb_delay  = 1;
   bit  rnd_ready = 1'b0;
   int  due_q[$];

   logic [27:0] lg      [0:1151];
   logic [27:0] fwd_ref [0:1151];
   logic [27:0] inv_ref [0:1151];
   logic [27:0] run1    [0:1151];
   int          lg_n        = 0;
   int          xf          = 0;
   int          wbc         = 0;
   int          maxpend     = 0;
   int          barrier_err = 0;
   int          stab_err    = 0;
   bit          prev_stall  = 1'b0;
   logic [27:0] prev_ent    = '0;
   logic [2:0]  last_layer  = 3'd7;

   function automatic logic [27:0] ent(input logic s, input logic i, input logic [2:0] l,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [6:0] z);
      return {s, i, l, a, b, z};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Datapath model: ready pattern and a fixed-latency writeback per accepted operation.
   always @(posedge clk) begin
      #1;
      cyc++;
      bus_if.wb_done = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         bus_if.wb_done = 1'b1;
      end
      bus_if.op_ready = rnd_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
   end

   always @(negedge clk) begin : mon
      logic [27:0] cur;
      cur = ent(bus_if.op_scale, bus_if.op_inv, layer, bus_if.addr_a, bus_if.addr_b,
                bus_if.zeta_addr);
      if (prev_stall && (!bus_if.op_valid || cur !== prev_ent)) stab_err++;
      prev_stall = bus_if.op_valid && !bus_if.op_ready;
      prev_ent   = cur;
      if (bus_if.op_valid && layer != last_layer && xf != wbc) barrier_err++;
      if (bus_if.op_valid && bus_if.op_ready) begin
         if (lg_n < 1152) lg[lg_n] = cur;
         lg_n++;
         xf++;
         due_q.push_back(cyc + wb_delay);
         last_layer = layer;
      end
      if (bus_if.wb_done) wbc++;
      if (xf - wbc > maxpend) maxpend = xf - wbc;
   end

   task automatic clr();
      lg_n        = 0;
      xf          = 0;
      wbc         = 0;
      maxpend     = 0;
      barrier_err = 0;
      stab_err    = 0;
      last_layer  = 3'd7;
      prev_stall  = 1'b0;
   endtask

   task automatic kick(input bit inv);
      clr();
      inverse = inv;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_latency_valid", {31'd0, bus_if.op_valid}, 32'd1);
      chk("start_busy", {31'd0, busy}, 32'd1);
   endtask

   // Waits for done; with poke, start is also pulsed mid-run and on the DONE cycle.
   task automatic wait_done(input bit poke, output int ndone, output int extra);
      int k;
      ndone = 0;
      extra = 0;
      k     = 0;
      while (ndone == 0 && k < 8000) begin
         @(posedge clk); #1;
         k++;
         if (poke) start = (k == 50 || k == 300);
         if (done) begin
            ndone++;
            chk("busy_low_on_done", {31'd0, busy}, 32'd0);
            if (poke) start = 1'b1;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy || bus_if.op_valid) extra++;
         @(posedge clk); #1;
      end
   endtask

   function automatic int diff_ref(input bit inv, input int n);
      int d;
      d = 0;
      for (int i = 0; i < n; i++) begin
         if (inv ? (lg[i] !== inv_ref[i]) : (lg[i] !== fwd_ref[i])) d++;
      end
      return d;
   endfunction

   initial begin
      int n, k, lay, nd, ex, d;

      // Reference sequences straight from the textbook loop nests.
      n = 0; k = 1; lay = 0;
      for (int len = 128; len >= 2; len = len / 2) begin
         for (int st = 0; st < 256; st = st + 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               fwd_ref[n] = ent(1'b0, 1'b0, 3'(lay), 8'(j), 8'(j + len), 7'(k));
               n++;
            end
            k++;
         end
         lay++;
      end
      n = 0; k = 127; lay = 0;
      for (int len = 2; len <= 128; len = len * 2) begin
         for (int st = 0; st < 256; st = st + 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               inv_ref[n] = ent(1'b0, 1'b1, 3'(lay), 8'(j), 8'(j + len), 7'(k));
               n++;
            end
            k--;
         end
         lay++;
      end
      for (int s = 0; s < 256; s++) begin
         inv_ref[896 + s] = ent(1'b1, 1'b1, 3'd7, 8'(s), 8'd0, 7'd0);
      end

      rst = 1'b1;
      start = 1'b0;
      inverse = 1'b0;
      bus_if.op_ready = 1'b1;
      bus_if.wb_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {1'b0, busy, done, bus_if.op_valid, bus_if.op_scale, bus_if.op_inv, layer,
           bus_if.addr_a, bus_if.addr_b, bus_if.zeta_addr}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", {30'd0, busy, bus_if.op_valid}, 32'd0);

      // Forward transform, always ready, writeback one cycle later.
      kick(1'b0);
      wait_done(1'b0, nd, ex);
      chk("fwd_done_count", nd, 1);
      chk("fwd_no_extra", ex, 0);
      chk("fwd_xfer_count", lg_n, 896);
      chk("fwd_op0", lg[0], ent(1'b0, 1'b0, 3'd0, 8'd0, 8'd128, 7'd1));
      chk("fwd_op127", lg[127], ent(1'b0, 1'b0, 3'd0, 8'd127, 8'd255, 7'd1));
      chk("fwd_op128", lg[128], ent(1'b0, 1'b0, 3'd1, 8'd0, 8'd64, 7'd2));
      chk("fwd_op192", lg[192], ent(1'b0, 1'b0, 3'd1, 8'd128, 8'd192, 7'd3));
      chk("fwd_op895", lg[895], ent(1'b0, 1'b0, 3'd6, 8'd253, 8'd255, 7'd127));
      chk("fwd_seq_vs_model", diff_ref(1'b0, 896), 0);
      chk("fwd_barrier", barrier_err, 0);
      for (int i = 0; i < 896; i++) run1[i] = lg[i];

      // Forward with random backpressure.
      rnd_ready = 1'b1;
      kick(1'b0);
      wait_done(1'b0, nd, ex);
      rnd_ready = 1'b0;
      chk("bp_done_count", nd, 1);
      chk("bp_xfer_count", lg_n, 896);
      d = 0;
      for (int i = 0; i < 896; i++) if (lg[i] !== run1[i]) d++;
      chk("bp_seq_vs_ready_run", d, 0);
      chk("bp_stall_stable", stab_err, 0);

      // Inverse transform with scale pass.
      kick(1'b1);
      wait_done(1'b0, nd, ex);
      chk("inv_done_count", nd, 1);
      chk("inv_no_extra", ex, 0);
      chk("inv_xfer_count", lg_n, 1152);
      chk("inv_op0", lg[0], ent(1'b0, 1'b1, 3'd0, 8'd0, 8'd2, 7'd127));
      chk("inv_layer6_op0", lg[768], ent(1'b0, 1'b1, 3'd6, 8'd0, 8'd128, 7'd1));
      chk("inv_scale0", lg[896], ent(1'b1, 1'b1, 3'd7, 8'd0, 8'd0, 7'd0));
      chk("inv_scale255", lg[1151], ent(1'b1, 1'b1, 3'd7, 8'd255, 8'd0, 7'd0));
      chk("inv_seq_vs_model", diff_ref(1'b1, 1152), 0);

      // Long writeback latency exercises the PIPE_MAX limit and the layer barrier.
      wb_delay = 20;
      kick(1'b0);
      wait_done(1'b0, nd, ex);
      chk("drain_done_count", nd, 1);
      chk("drain_xfer_count", lg_n, 896);
      chk("drain_barrier", barrier_err, 0);
      chk("drain_max_outstanding", maxpend, 8);
      chk("drain_seq_vs_model", diff_ref(1'b0, 896), 0);
      wb_delay = 1;
      repeat (4) @(posedge clk);
      #1;

      // Reset in the middle of layer 3 of an inverse transform.
      kick(1'b1);
      k = 0;
      while (lg_n < 400 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("mid_layer", {29'd0, layer}, 32'd3);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_outputs",
          {1'b0, busy, done, bus_if.op_valid, bus_if.op_scale, bus_if.op_inv, layer,
           bus_if.addr_a, bus_if.addr_b, bus_if.zeta_addr}, 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      kick(1'b1);
      wait_done(1'b0, nd, ex);
      chk("rerun_done_count", nd, 1);
      chk("rerun_xfer_count", lg_n, 1152);
      chk("rerun_seq_vs_model", diff_ref(1'b1, 1152), 0);

      // Starts while busy and on the DONE cycle must be ignored.
      kick(1'b0);
      wait_done(1'b1, nd, ex);
      chk("poke_done_count", nd, 1);
      chk("poke_no_restart", ex, 0);
      chk("poke_xfer_count", lg_n, 896);
      chk("poke_seq_vs_model", diff_ref(1'b0, 896), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
